button_press_counter: RTL and testbench
=======================================

// Module: button_press_counter
// PURPOSE
//  Input-side companion to the board's LED counter. Samples one raw push-button on CLK_IN,
//  synchronises and debounces it, and counts clean presses. A long hold clears the count.
//  GLED5 shows the debounced button level. RLED1..RLED4 show the count, with RLED1 as the MSB.
// PARAMETERS
//  CLK_HZ       12_000_000  CLK_IN frequency in Hz
//  DEBOUNCE_MS  10          stable time required before a level change is accepted
//  LONG_MS      1000        hold time after accepted press that clears the count
//  BTN_ACT_LOW  1           1: BTN_IN low = pressed; 0: BTN_IN high = pressed
//  Derived: DB_CYC = CLK_HZ/1000*DEBOUNCE_MS and LONG_CYC = CLK_HZ/1000*LONG_MS.
//  Both must be >= 2; elaboration error otherwise.
// PORTS
//  CLK_IN  in   1  system clock; single clock domain
//  RST_IN  in   1  synchronous, active-high reset
//  BTN_IN  in   1  raw asynchronous button pin
//  GLED5   out  1  debounced pressed level
//  RLED1   out  1  count[3] (MSB)
//  RLED2   out  1  count[2]
//  RLED3   out  1  count[1]
//  RLED4   out  1  count[0]
// BEHAVIOUR
//  - Reset: synchroniser flops load the released level. State = RELEASED. Timer = 0, count = 0,
//    long_done = 0. All LEDs = 0. Reset mid-debounce or mid-hold aborts with no count change.
//  - Sync: 2-flop synchroniser, then polarity fold to pressed = 1 (s_prs).
//  - FSM, evaluated every edge:
//    RELEASED : s_prs -> DB_PRESS, timer = 0.
//    DB_PRESS : !s_prs -> RELEASED (glitch rejected, no count).
//               timer == DB_CYC-1 -> PRESSED, count += 1 (4-bit, 4'hF wraps to 4'h0),
//               timer = 0, long_done = 0. Otherwise timer += 1.
//    PRESSED  : !s_prs -> DB_REL, timer = 0.
//               timer == LONG_CYC-1 && !long_done -> count = 0, long_done = 1, timer holds.
//               Otherwise timer += 1, saturating.
//    DB_REL   : s_prs -> PRESSED. timer = 0. long_done is kept, so the count is cleared once per hold.
//               timer == DB_CYC-1 -> RELEASED. Otherwise timer += 1.
//  - Simultaneous events: the release check has priority over the long-hold check in PRESSED.
//  - Latency: the count and GLED5 rise 3+DB_CYC edges after BTN_IN goes to the pressed level
//    (2 sync edges, 1 entry edge, then DB_CYC timer edges).
//    GLED5 falls 3+DB_CYC edges after a stable release.
//  - GLED5 = 1 in PRESSED and DB_REL, 0 otherwise. All outputs are registered or decoded from
//    registered state; no combinational path from BTN_IN.
//  - Timer width = clog2(max(DB_CYC, LONG_CYC)). Timer compares are exact-equal.
// STRUCTURE
//  - Shared package btn_pkg holds:
//    - typedef enum {RELEASED, DB_PRESS, PRESSED, DB_REL} btn_state_t
//    - function ms_to_cyc(clk_hz, ms)
//    - localparam COUNT_W = 4
//  - Sub-module sync_2ff (WIDTH, RST_VAL): a reusable synchroniser for future pin inputs.
//  - Everything else is one clocked always block plus output decode.
// TESTING  (bench overrides CLK_HZ=1000, DEBOUNCE_MS=4, LONG_MS=20 -> DB_CYC=4, LONG_CYC=20;
//           BTN_ACT_LOW=1)
//  1 Reset: RST_IN=1 for 3 edges with BTN_IN=1 -> GLED5=0, RLED1..4=0000. Hold with no change.
//  2 Clean press: BTN_IN=0 at edge 0 -> GLED5=1 and LEDs=0001 exactly at edge 7.
//    Release -> GLED5=0 7 edges later.
//  3 Bounce: BTN_IN low for 3 edges, high 1, low 2, high -> count stays 0000, GLED5 never 1.
//  4 Wrap: 16 clean presses -> LEDs step 0001..1111, then 0000 on the 16th.
//  5 Long hold: press from count 0101 -> 0110 at accept. Hold 20 more edges -> 0000.
//    Keep holding 50 edges -> stays 0000. 2-edge release bounce mid-hold -> no second clear.
//  6 Reset mid-debounce: assert RST_IN 2 edges after entering DB_PRESS with count 0011
//    -> count 0000, state RELEASED, no increment after RST_IN drops while BTN_IN stays high.

Source files
------------

// File: rtl/btn_pkg.sv
// rtl/btn_pkg.sv - shared types and helpers for the push-button counter
package btn_pkg;

    localparam int COUNT_W = 4;

    typedef enum logic [1:0] {
        RELEASED = 2'd0,
        DB_PRESS = 2'd1,
        PRESSED  = 2'd2,
        DB_REL   = 2'd3
    } btn_state_t;

    function automatic int ms_to_cyc(input int clk_hz, input int ms);
        return clk_hz / 1000 * ms;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchroniser with synchronous active-high reset
module sync_2ff #(
    parameter int         WIDTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= RST_VAL;
            dout <= RST_VAL;
        end else begin
            meta <= din;
            dout <= meta;
        end
    end

endmodule

// File: rtl/button_press_counter.sv
// rtl/button_press_counter.sv - debounced push-button press counter with long-hold clear
module button_press_counter
    import btn_pkg::*;
#(
    parameter int CLK_HZ      = 12_000_000,
    parameter int DEBOUNCE_MS = 10,
    parameter int LONG_MS     = 1000,
    parameter bit BTN_ACT_LOW = 1'b1
) (
    input  logic CLK_IN,
    input  logic RST_IN,
    input  logic BTN_IN,
    output logic GLED5,
    output logic RLED1,
    output logic RLED2,
    output logic RLED3,
    output logic RLED4
);

    localparam int DB_CYC   = ms_to_cyc(CLK_HZ, DEBOUNCE_MS);
    localparam int LONG_CYC = ms_to_cyc(CLK_HZ, LONG_MS);
    localparam int MAX_CYC  = (DB_CYC > LONG_CYC) ? DB_CYC : LONG_CYC;
    localparam int TIMER_W  = $clog2(MAX_CYC);

    localparam logic [TIMER_W-1:0] DB_LAST   = TIMER_W'(DB_CYC - 1);
    localparam logic [TIMER_W-1:0] LONG_LAST = TIMER_W'(LONG_CYC - 1);
    localparam logic               REL_LVL   = BTN_ACT_LOW;

    if (DB_CYC < 2 || LONG_CYC < 2) begin : g_bad_params
        $error("button_press_counter: DB_CYC and LONG_CYC must both be >= 2");
    end

    logic                 s_raw;
    logic                 s_prs;
    btn_state_t           state, state_n;
    logic [TIMER_W-1:0]   timer, timer_n;
    logic [COUNT_W-1:0]   count, count_n;
    logic                 long_done, long_done_n;

    sync_2ff #(
        .WIDTH   (1),
        .RST_VAL (REL_LVL)
    ) u_sync (
        .clk  (CLK_IN),
        .rst  (RST_IN),
        .din  (BTN_IN),
        .dout (s_raw)
    );

    assign s_prs = BTN_ACT_LOW ? ~s_raw : s_raw;

    always_ff @(posedge CLK_IN) begin
        if (RST_IN) begin
            state     <= RELEASED;
            timer     <= '0;
            count     <= '0;
            long_done <= 1'b0;
        end else begin
            state     <= state_n;
            timer     <= timer_n;
            count     <= count_n;
            long_done <= long_done_n;
        end
    end

    always_comb begin
        state_n     = state;
        timer_n     = timer;
        count_n     = count;
        long_done_n = long_done;
        case (state)
            RELEASED: begin
                if (s_prs) begin
                    state_n = DB_PRESS;
                    timer_n = '0;
                end
            end
            DB_PRESS: begin
                if (!s_prs) begin
                    state_n = RELEASED;
                end else if (timer == DB_LAST) begin
                    state_n     = PRESSED;
                    count_n     = count + COUNT_W'(1);
                    timer_n     = '0;
                    long_done_n = 1'b0;
                end else begin
                    timer_n = timer + TIMER_W'(1);
                end
            end
            PRESSED: begin
                // Release wins over a coincident long-hold expiry
                if (!s_prs) begin
                    state_n = DB_REL;
                    timer_n = '0;
                end else if (timer == LONG_LAST && !long_done) begin
                    count_n     = '0;
                    long_done_n = 1'b1;
                end else if (timer != '1) begin
                    timer_n = timer + TIMER_W'(1);
                end
            end
            DB_REL: begin
                if (s_prs) begin
                    state_n = PRESSED;
                    timer_n = '0;
                end else if (timer == DB_LAST) begin
                    state_n = RELEASED;
                end else begin
                    timer_n = timer + TIMER_W'(1);
                end
            end
            default: state_n = RELEASED;
        endcase
    end

    assign GLED5 = (state == PRESSED) || (state == DB_REL);
    assign RLED1 = count[3];
    assign RLED2 = count[2];
    assign RLED3 = count[1];
    assign RLED4 = count[0];

endmodule

// File: tb/tb_button_press_counter.sv
// tb/tb_button_press_counter.sv - directed self-checking bench for button_press_counter
module tb_button_press_counter;

    logic clk = 1'b0;
    logic rst;
    logic btn;
    logic gled5, rled1, rled2, rled3, rled4;

    int vectors     = 0;
    int miscompares = 0;
    logic gled_hi_seen;
    logic gled_lo_seen;

    button_press_counter #(
        .CLK_HZ      (1000),
        .DEBOUNCE_MS (4),
        .LONG_MS     (20),
        .BTN_ACT_LOW (1'b1)
    ) dut (
        .CLK_IN (clk),
        .RST_IN (rst),
        .BTN_IN (btn),
        .GLED5  (gled5),
        .RLED1  (rled1),
        .RLED2  (rled2),
        .RLED3  (rled3),
        .RLED4  (rled4)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            gled_hi_seen = gled_hi_seen | gled5;
            gled_lo_seen = gled_lo_seen | ~gled5;
        end
    endtask

    task automatic check(input string tag, input logic [4:0] obs, input logic [4:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    function automatic logic [4:0] outs();
        return {gled5, rled1, rled2, rled3, rled4};
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        btn = 1'b1;
        tick(3);
        rst = 1'b0;
        tick(1);
    endtask

    task automatic press_release();
        btn = 1'b0;
        tick(7);
        btn = 1'b1;
        tick(8);
    endtask

    initial begin
        gled_hi_seen = 1'b0;
        gled_lo_seen = 1'b0;
        rst = 1'b1;
        btn = 1'b1;

        // Reset
        tick(3);
        check("reset", outs(), 5'b0_0000);
        tick(3);
        check("reset_hold", outs(), 5'b0_0000);
        rst = 1'b0;
        tick(5);
        check("idle_after_reset", outs(), 5'b0_0000);

        // Clean press: accept exactly 7 edges after the pin goes low
        btn = 1'b0;
        tick(6);
        check("press_edge6", outs(), 5'b0_0000);
        tick(1);
        check("press_edge7", outs(), 5'b1_0001);
        btn = 1'b1;
        tick(6);
        check("release_edge6", outs(), 5'b1_0001);
        tick(1);
        check("release_edge7", outs(), 5'b0_0001);

        // Bounce rejected
        do_reset();
        gled_hi_seen = 1'b0;
        btn = 1'b0; tick(3);
        btn = 1'b1; tick(1);
        btn = 1'b0; tick(2);
        btn = 1'b1; tick(10);
        check("bounce_count", outs(), 5'b0_0000);
        check("bounce_gled_never", {4'b0, gled_hi_seen}, 5'b0_0000);

        // Wrap through 16 presses
        do_reset();
        for (int i = 1; i <= 16; i++) begin
            btn = 1'b0;
            tick(7);
            check($sformatf("wrap_%0d", i), outs(), {1'b1, 4'(i)});
            btn = 1'b1;
            tick(8);
        end

        // Long hold clears once
        do_reset();
        repeat (5) press_release();
        check("pre_hold_count", outs(), 5'b0_0101);
        btn = 1'b0;
        tick(7);
        check("hold_accept", outs(), 5'b1_0110);
        tick(19);
        check("hold_edge19", outs(), 5'b1_0110);
        tick(1);
        check("hold_edge20", outs(), 5'b1_0000);
        tick(50);
        check("hold_plus50", outs(), 5'b1_0000);
        gled_lo_seen = 1'b0;
        btn = 1'b1; tick(2);
        btn = 1'b0; tick(30);
        check("hold_bounce", outs(), 5'b1_0000);
        check("hold_bounce_gled_steady", {4'b0, gled_lo_seen}, 5'b0_0000);
        btn = 1'b1;
        tick(8);
        check("hold_release", outs(), 5'b0_0000);

        // Reset in the middle of a debounce
        do_reset();
        repeat (3) press_release();
        check("pre_abort_count", outs(), 5'b0_0011);
        btn = 1'b0;
        tick(5);
        check("mid_debounce", outs(), 5'b0_0011);
        rst = 1'b1;
        btn = 1'b1;
        tick(2);
        check("abort_reset", outs(), 5'b0_0000);
        rst = 1'b0;
        tick(20);
        check("abort_no_incr", outs(), 5'b0_0000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
